tmr_voter_tracker: RTL and testbench

TMR_VOTER_TRACKER -- requirements
Module: tmr_voter_tracker

---
 rtl/voter_pkg.sv | 24 ++
 rtl/voter_compare.sv | 37 +++
 rtl/tmr_voter_tracker.sv | 225 ++++++++++++++++++++++
 tb/tb_tmr_voter_tracker.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/voter_pkg.sv
// Shared definitions for the TMR voter: operating-mode encodings,
// one-hot channel indices and the miscompare counter width.
package voter_pkg;

  typedef enum logic [1:0] {
    MODE_TMR    = 2'b00,
    MODE_DUPLEX = 2'b01,
    MODE_FAILED = 2'b10
  } mode_e;

  // Channel bit positions in faulty_ch / ch_disabled.
  localparam int unsigned CH_A = 0;
  localparam int unsigned CH_B = 1;
  localparam int unsigned CH_C = 2;

  // One-hot channel masks.
  localparam logic [2:0] CH_A_OH = 3'b001;
  localparam logic [2:0] CH_B_OH = 3'b010;
  localparam logic [2:0] CH_C_OH = 3'b100;

  // Miscompare counters only need to reach FAULT_LIMIT (max 15).
  localparam int unsigned MISCMP_W = 4;

endpackage

// File: rtl/voter_compare.sv
// Combinational compare stage: pairwise XOR equality, bitwise majority
// and lone-dissenter decode for three redundant channels.
module voter_compare
  import voter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] c_i,
  output logic             eq_ab_o,
  output logic             eq_bc_o,
  output logic             eq_ac_o,
  output logic             all_eq_o,
  output logic             all_diff_o,
  output logic [WIDTH-1:0] majority_o,
  output logic [2:0]       dissent_o
);

  // Pairwise equality: a pair matches when their XOR has no set bit.
  always_comb begin
    eq_ab_o    = ~|(a_i ^ b_i);
    eq_bc_o    = ~|(b_i ^ c_i);
    eq_ac_o    = ~|(a_i ^ c_i);
    all_eq_o   = eq_ab_o & eq_bc_o;
    all_diff_o = ~eq_ab_o & ~eq_bc_o & ~eq_ac_o;
    majority_o = (a_i & b_i) | (b_i & c_i) | (a_i & c_i);
  end

  // A channel is the lone dissenter when the other two agree and it does not.
  always_comb begin
    dissent_o = ({3{eq_bc_o & ~eq_ab_o}} & CH_A_OH)
              | ({3{eq_ac_o & ~eq_ab_o}} & CH_B_OH)
              | ({3{eq_ab_o & ~eq_bc_o}} & CH_C_OH);
  end

endmodule

// File: rtl/tmr_voter_tracker.sv
// Two-stage TMR voter with fault tracking. Stage 1 registers the three
// channels; stage 2 votes, drives registered outputs and updates the
// per-channel miscompare counters, disable flags, mode FSM and error count.
module tmr_voter_tracker
  import voter_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int FAULT_LIMIT = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic             clear_faults,
  output logic             out_valid,
  output logic [WIDTH-1:0] out,
  output logic             error_detected,
  output logic             invalid_output,
  output logic [2:0]       faulty_ch,
  output logic [2:0]       ch_disabled,
  output logic [1:0]       mode,
  output logic [CNT_W-1:0] err_count
);

  // A counter already at FAULT_LIMIT-1 that miscompares again reaches the limit.
  localparam logic [MISCMP_W-1:0] LIMIT_M1 = MISCMP_W'(FAULT_LIMIT - 1);

  // Stage 1
  logic             s1_valid_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;

  // Compare results
  logic             eq_ab, eq_bc, eq_ac, all_eq, all_diff;
  logic [WIDTH-1:0] majority;
  logic [2:0]       dissent;

  // Tracker state
  mode_e                      mode_q, mode_d;
  logic [2:0]                 dis_q, dis_d;
  logic [2:0][MISCMP_W-1:0]   miscmp_q, miscmp_d;
  logic [CNT_W-1:0]           err_cnt_q, err_cnt_d;

  // Vote decode
  logic             pair_eq;
  logic [WIDTH-1:0] pair_value;
  logic [WIDTH-1:0] vote_value;
  logic             vote_err, vote_inv;
  logic [2:0]       vote_faulty;

  // Stage 2 output registers
  logic             out_valid_q;
  logic [WIDTH-1:0] out_q;
  logic             err_q, inv_q;
  logic [2:0]       faulty_q;

  // Stage-1 valid flag; reset flushes any sample waiting here.
  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) s1_valid_q <= 1'b0;
    else       s1_valid_q <= in_valid;
  end

  // Stage-1 channel capture.
  // NOTE: data registers carry no reset; s1_valid_q alone decides whether they are consumed.
  always_ff @(posedge clock) begin
    if (in_valid) begin
      a_q <= a;
      b_q <= b;
      c_q <= c;
    end
  end

  voter_compare #(.WIDTH(WIDTH)) u_compare (
    .a_i        (a_q),
    .b_i        (b_q),
    .c_i        (c_q),
    .eq_ab_o    (eq_ab),
    .eq_bc_o    (eq_bc),
    .eq_ac_o    (eq_ac),
    .all_eq_o   (all_eq),
    .all_diff_o (all_diff),
    .majority_o (majority),
    .dissent_o  (dissent)
  );

  // Mode FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) mode_q <= MODE_TMR;
    else       mode_q <= mode_d;
  end

  // Output decode: voted value and status for the sample in stage 2.
  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    // In DUPLEX the vote uses the pair of channels that is still enabled.
    pair_eq    = eq_ab;
    pair_value = a_q;
    if (dis_q[CH_A]) begin
      pair_eq    = eq_bc;
      pair_value = b_q;
    end else if (dis_q[CH_B]) begin
      pair_eq    = eq_ac;
      pair_value = a_q;
    end

    vote_value  = out_q;
    vote_err    = 1'b0;
    vote_inv    = 1'b0;
    vote_faulty = '0;
    case (mode_q)
      MODE_TMR: begin
        vote_value = majority;
        if (all_diff) begin
          vote_err = 1'b1;
          vote_inv = 1'b1;
        end else if (!all_eq) begin
          vote_err    = 1'b1;
          vote_faulty = dissent;
        end
      end
      MODE_DUPLEX: begin
        if (pair_eq) begin
          vote_value = pair_value;
        end else begin
          vote_err = 1'b1;
          vote_inv = 1'b1;
        end
      end
      default: begin
        vote_err = 1'b1;
        vote_inv = 1'b1;
      end
    endcase
  end

  // Next-state decode for mode, disable flags, miscompare and error counters.
  always_comb begin
    mode_d    = mode_q;
    dis_d     = dis_q;
    miscmp_d  = miscmp_q;
    err_cnt_d = err_cnt_q;
    if (clear_faults) begin
      // Re-arm wins over whatever the stage-2 sample would have recorded.
      mode_d    = MODE_TMR;
      dis_d     = '0;
      miscmp_d  = '0;
      err_cnt_d = '0;
    end else if (s1_valid_q) begin
      if (vote_err && (err_cnt_q != {CNT_W{1'b1}})) err_cnt_d = err_cnt_q + 1'b1;
      case (mode_q)
        MODE_TMR: begin
          // A three-way split gives no majority to judge channels against.
          if (!all_diff) begin
            for (int i = 0; i < 3; i++) begin
              if (dissent[i]) begin
                if (miscmp_q[i] != {MISCMP_W{1'b1}}) miscmp_d[i] = miscmp_q[i] + 1'b1;
                if (miscmp_q[i] >= LIMIT_M1) begin
                  dis_d[i] = 1'b1;
                  mode_d   = MODE_DUPLEX;
                end
              end else begin
                miscmp_d[i] = '0;
              end
            end
          end
        end
        MODE_DUPLEX: begin
          if (pair_eq) begin
            for (int i = 0; i < 3; i++) begin
              if (!dis_q[i]) miscmp_d[i] = '0;
            end
          end else begin
            mode_d = MODE_FAILED;
          end
        end
        default: ;
      endcase
    end
  end

  // Tracker state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dis_q     <= '0;
      miscmp_q  <= '0;
      err_cnt_q <= '0;
    end else begin
      dis_q     <= dis_d;
      miscmp_q  <= miscmp_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Stage-2 output registers; hold on idle cycles except faulty_ch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      err_q       <= 1'b0;
      inv_q       <= 1'b0;
      faulty_q    <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      faulty_q    <= s1_valid_q ? vote_faulty : 3'b000;
      if (s1_valid_q) begin
        out_q <= vote_value;
        err_q <= vote_err;
        inv_q <= vote_inv;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out            = out_q;
  assign error_detected = err_q;
  assign invalid_output = inv_q;
  assign faulty_ch      = faulty_q;
  assign ch_disabled    = dis_q;
  assign mode           = mode_q;
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_tmr_voter_tracker.sv
// Directed self-checking bench for tmr_voter_tracker (WIDTH=32, FAULT_LIMIT=4, CNT_W=8).
module tb_tmr_voter_tracker;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic [31:0] a, b, c;
  logic        clear_faults;
  logic        out_valid;
  logic [31:0] out;
  logic        error_detected;
  logic        invalid_output;
  logic [2:0]  faulty_ch;
  logic [2:0]  ch_disabled;
  logic [1:0]  mode;
  logic [7:0]  err_count;

  int checks_passed = 0;
  int checks_total  = 0;

  tmr_voter_tracker #(.WIDTH(32), .FAULT_LIMIT(4), .CNT_W(8)) dut (
    .clock          (clock),
    .reset          (reset),
    .in_valid       (in_valid),
    .a              (a),
    .b              (b),
    .c              (c),
    .clear_faults   (clear_faults),
    .out_valid      (out_valid),
    .out            (out),
    .error_detected (error_detected),
    .invalid_output (invalid_output),
    .faulty_ch      (faulty_ch),
    .ch_disabled    (ch_disabled),
    .mode           (mode),
    .err_count      (err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks_total++;
    assert (obs === exp) checks_passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one set of inputs across a rising edge; outputs are read 1 time unit later.
  task automatic drive(input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] cv, input logic clr);
    in_valid     = v;
    a            = av;
    b            = bv;
    c            = cv;
    clear_faults = clr;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    clear_faults = 1'b0;
    a            = 32'hFFFF_FFFF;
    b            = 32'hFFFF_FFFF;
    c            = 32'hFFFF_FFFF;
    repeat (2) @(posedge clock);
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out", out, 32'h0);
    chk("rst error", error_detected, 1'b0);
    chk("rst invalid", invalid_output, 1'b0);
    chk("rst faulty", faulty_ch, 3'b000);
    chk("rst disabled", ch_disabled, 3'b000);
    chk("rst mode", mode, 2'b00);
    chk("rst err_count", err_count, 8'd0);
    reset = 1'b0;

    // All channels agree.
    drive(1'b1, 32'h1234_5678, 32'h1234_5678, 32'h1234_5678, 1'b0);
    chk("agree latency1 out_valid", out_valid, 1'b0);
    idle();
    chk("agree out_valid", out_valid, 1'b1);
    chk("agree out", out, 32'h1234_5678);
    chk("agree error", error_detected, 1'b0);
    chk("agree invalid", invalid_output, 1'b0);
    chk("agree faulty", faulty_ch, 3'b000);
    chk("agree mode", mode, 2'b00);

    // Channel b dissents four times back to back.
    drive(1'b1, 32'h0, 32'hFFFF_0000, 32'h0, 1'b0);
    chk("idle out_valid", out_valid, 1'b0);
    chk("idle faulty", faulty_ch, 3'b000);
    chk("idle out held", out, 32'h1234_5678);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 32'h0, 32'hFFFF_0000, 32'h0, 1'b0);
      chk("bfault out", out, 32'h0);
      chk("bfault faulty", faulty_ch, 3'b010);
      chk("bfault error", error_detected, 1'b1);
      chk("bfault mode", mode, 2'b00);
      chk("bfault disabled", ch_disabled, 3'b000);
      chk("bfault err_count", err_count, 8'(i));
    end
    idle();
    chk("bfault4 out", out, 32'h0);
    chk("bfault4 faulty", faulty_ch, 3'b010);
    chk("bfault4 disabled", ch_disabled, 3'b010);
    chk("bfault4 mode", mode, 2'b01);
    chk("bfault4 err_count", err_count, 8'd4);

    // DUPLEX with b disabled: agreement ignores b, then a/c split.
    drive(1'b1, 32'hAAAA_5555, 32'h0000_0001, 32'hAAAA_5555, 1'b0);
    chk("duplex idle out_valid", out_valid, 1'b0);
    drive(1'b1, 32'h5, 32'hDEAD, 32'h6, 1'b0);
    chk("duplex agree out", out, 32'hAAAA_5555);
    chk("duplex agree error", error_detected, 1'b0);
    chk("duplex agree invalid", invalid_output, 1'b0);
    chk("duplex agree mode", mode, 2'b01);
    idle();
    chk("duplex split out_valid", out_valid, 1'b1);
    chk("duplex split error", error_detected, 1'b1);
    chk("duplex split invalid", invalid_output, 1'b1);
    chk("duplex split out held", out, 32'hAAAA_5555);
    chk("duplex split faulty", faulty_ch, 3'b000);
    chk("duplex split mode", mode, 2'b10);
    chk("duplex split err_count", err_count, 8'd5);

    // FAILED sample in stage 2 coincides with clear_faults; next sample sits in stage 1.
    drive(1'b1, 32'h7, 32'h7, 32'h7, 1'b0);
    chk("failed idle mode", mode, 2'b10);
    drive(1'b1, 32'h9, 32'h9, 32'h9, 1'b1);
    chk("clear out_valid", out_valid, 1'b1);
    chk("clear invalid", invalid_output, 1'b1);
    chk("clear error", error_detected, 1'b1);
    chk("clear out held", out, 32'hAAAA_5555);
    chk("clear mode", mode, 2'b00);
    chk("clear disabled", ch_disabled, 3'b000);
    chk("clear err_count", err_count, 8'd0);
    drive(1'b1, 32'h1, 32'h2, 32'h4, 1'b0);
    chk("post clear out", out, 32'h9);
    chk("post clear error", error_detected, 1'b0);
    chk("post clear invalid", invalid_output, 1'b0);
    chk("post clear mode", mode, 2'b00);

    // Three-way split in TMR.
    idle();
    chk("split out", out, 32'h0);
    chk("split invalid", invalid_output, 1'b1);
    chk("split error", error_detected, 1'b1);
    chk("split faulty", faulty_ch, 3'b000);
    chk("split mode", mode, 2'b00);
    chk("split err_count", err_count, 8'd1);

    // c dissents 3x, agreement resets its counter, then 3x more: never disabled.
    repeat (3) drive(1'b1, 32'h5, 32'h5, 32'h6, 1'b0);
    drive(1'b1, 32'h5, 32'h5, 32'h5, 1'b0);
    chk("cfault3 faulty", faulty_ch, 3'b100);
    chk("cfault3 out", out, 32'h5);
    chk("cfault3 disabled", ch_disabled, 3'b000);
    drive(1'b1, 32'h5, 32'h5, 32'h6, 1'b0);
    chk("cagree faulty", faulty_ch, 3'b000);
    chk("cagree error", error_detected, 1'b0);
    repeat (2) drive(1'b1, 32'h5, 32'h5, 32'h6, 1'b0);
    idle();
    chk("cfault6 faulty", faulty_ch, 3'b100);
    chk("cfault6 disabled", ch_disabled, 3'b000);
    chk("cfault6 mode", mode, 2'b00);
    chk("cfault6 err_count", err_count, 8'd7);

    // Saturation: 7 + 250 errors clamps at 255.
    repeat (250) drive(1'b1, 32'h1, 32'h2, 32'h4, 1'b0);
    idle();
    chk("sat err_count", err_count, 8'd255);
    chk("sat mode", mode, 2'b00);
    chk("sat invalid", invalid_output, 1'b1);
    idle();
    chk("sat hold out_valid", out_valid, 1'b0);
    chk("sat hold err_count", err_count, 8'd255);

    // Mid-stream reset with two samples in flight.
    drive(1'b1, 32'h1, 32'h1, 32'h1, 1'b0);
    drive(1'b1, 32'h2, 32'h2, 32'h2, 1'b0);
    chk("prerst out_valid", out_valid, 1'b1);
    chk("prerst out", out, 32'h1);
    #2;
    reset    = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("midrst out_valid", out_valid, 1'b0);
    chk("midrst out", out, 32'h0);
    chk("midrst error", error_detected, 1'b0);
    chk("midrst invalid", invalid_output, 1'b0);
    chk("midrst faulty", faulty_ch, 3'b000);
    chk("midrst disabled", ch_disabled, 3'b000);
    chk("midrst mode", mode, 2'b00);
    chk("midrst err_count", err_count, 8'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    idle();
    chk("flush1 out_valid", out_valid, 1'b0);
    idle();
    chk("flush2 out_valid", out_valid, 1'b0);
    drive(1'b1, 32'h3, 32'h3, 32'h3, 1'b0);
    chk("restart latency1 out_valid", out_valid, 1'b0);
    idle();
    chk("restart out_valid", out_valid, 1'b1);
    chk("restart out", out, 32'h3);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
